jtdd_timing: RTL and testbench
==============================

# jtdd_timing

Video timing generator for the Double Dragon core. Runs the pixel-rate horizontal and vertical counters and derives the blanking, sync and interrupt-timing signals. Sits directly upstream of the main CPU block, which consumes `VBL` (NMI source) and `IMS` (FIRQ source, vertical position bit 3). The same `H`/`V`/blanking outputs also drive the char, scroll and object renderers and the video output.

## Interface
Parameters:
- `HTOTAL`, 384: pixel clocks per line; `H` counts 0..HTOTAL-1.
- `VTOTAL`, 272: lines per frame; `V` counts 0..VTOTAL-1.
- `HB_START`, 256: first horizontally blanked pixel; blank runs to HTOTAL-1.
- `HS_START`, 288: first `HS` pixel.
- `HS_LEN`, 32: `HS` width in pixels.
- `VB_END`, 8: first visible line.
- `VB_START`, 248: first blanked line; blank runs VB_START..VTOTAL-1 and 0..VB_END-1.
- `VS_START`, 252: first `VS` line.
- `VS_LEN`, 4: `VS` height in lines.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `pxl_cen`, in, 1: 6 MHz pixel clock enable. Nothing advances without it.
- `H`, out, 9: horizontal count.
- `V`, out, 9: vertical count.
- `HBL`, out, 1: horizontal blank.
- `VBL`, out, 1: vertical blank.
- `HS`, out, 1: horizontal sync, active high.
- `VS`, out, 1: vertical sync, active high.
- `IMS`, out, 1: equals `V[3]`, registered with `V`.
- `LHBL`, out, 1: line-active = ~HBL & ~VBL.
- `frame_start`, out, 1: one-`clk` strobe when the counters move to H=0, V=0.

## Operation
- On each `pxl_cen`:
  - `H` increments.
  - At `H`=HTOTAL-1, `H` wraps to 0 and `V` increments.
  - At `V`=VTOTAL-1 on that same wrap, `V` wraps to 0.
- Counter widths are 9 bits. No overflow is reachable for in-range parameters. Parameters outside 1..511 are illegal; the implementation must flag this with a simulation-only check.
- `HBL` is 1 for H in [HB_START, HTOTAL-1].
- `HS` is 1 for H in [HS_START, HS_START+HS_LEN-1].
- `VBL`, `VS` and `IMS` are computed from the next `V` value and change only on the `pxl_cen` where `H` wraps to 0. They never change mid-line.
- `VBL` is 1 for V ≥ VB_START or V < VB_END.
- `VS` is 1 for V in [VS_START, VS_START+VS_LEN-1].
- `frame_start` is high for exactly the `clk` cycle following the `pxl_cen` that loads H=0, V=0. It is low otherwise, including the `pxl_cen` gaps.
- Consumers see exactly one rising `VBL` edge per frame and VTOTAL/16 = 17 rising `IMS` edges per frame.
- Nominal frame rate: 6 MHz / (384 × 272) ≈ 57.44 Hz.
- Reset: H=0, V=0, HBL=0, VBL=1, HS=0, VS=0, IMS=0, LHBL=0, frame_start=0.
  - Assertion mid-frame forces all of these values immediately (asynchronous).
  - After release, the first `pxl_cen` moves H to 1. The frame starting at reset is therefore complete but has no `frame_start` strobe.

## Timing
- All outputs are registered and updated on the same `pxl_cen` edge as `H`/`V`. Flag-to-counter latency is zero: on the cycle `H` reads 256, `HBL` already reads 1.
- `LHBL` is registered from the next-state values, so it is aligned with `HBL`/`VBL`.
- `pxl_cen` held low freezes every output, and `frame_start` stays low.
- `pxl_cen` high every `clk` is legal. The block must behave identically at that rate.
- Boundaries:
  - H=HTOTAL-1 → 0: `HBL` falls.
  - V=VB_END-1 → VB_END at H wrap: `VBL` falls.
  - V=VTOTAL-1 → 0: `VBL` stays 1 and `frame_start` pulses.
  - `IMS` toggles on lines 8, 16, …, 264 and falls again on the wrap to line 0.

## Structure
- Default timing constants go in the shared header `jtdd_timing.vh`, included by this block and by the renderers: HTOTAL, VTOTAL, HB_START, VB_START, VB_END, HS/VS values.
- Natural sub-module: `jtdd_timing_cnt`, a parametric wrap counter with a carry-out. It is instantiated twice: for `H`, and for `V` with the H carry as its enable.
- Flag decode is a single always block in the top.

## Test plan
- Reset mid-frame (V=100, H=200), release, then count `pxl_cen`: H=1 after the first one, and H=0 with V=1 after 384.
- Run 3 full frames: exactly 104448 `pxl_cen` between `frame_start` strobes, and one `VBL` rising edge per frame at V=248, H=0.
- Scan line 247 → 248 → 8: `VBL` rises on the H wrap into 248, stays 1 through V=0..7, and falls on the H wrap into V=8. It is never changed at H≠0.
- Count `IMS` rising edges over one frame: 17 edges, first at V=8. `IMS`=`V[3]` on every cycle.
- Check `HS`/`VS` widths: `HS` high exactly 32 `pxl_cen` starting at H=288; `VS` high exactly 4 lines starting at V=252.
- `pxl_cen` held low for 50 `clk` mid-line: no output changes. Then `pxl_cen`=1 every `clk`: counts match the gapped run cycle-for-cycle in `pxl_cen` terms.

Source files
------------

// File: rtl/jtdd_timing_pkg.sv
// Default video timing constants for the Double Dragon core and helpers shared by
// the timing generator and the renderers.
package jtdd_timing_pkg;
    localparam int HTOTAL_DEF   = 384;
    localparam int VTOTAL_DEF   = 272;
    localparam int HB_START_DEF = 256;
    localparam int HS_START_DEF = 288;
    localparam int HS_LEN_DEF   = 32;
    localparam int VB_END_DEF   = 8;
    localparam int VB_START_DEF = 248;
    localparam int VS_START_DEF = 252;
    localparam int VS_LEN_DEF   = 4;

    function automatic logic in_win(input logic [8:0] x, input int lo, input int len);
        return (int'(x) >= lo) && (int'(x) < lo + len);
    endfunction

    function automatic logic param_ok(input int p);
        return (p >= 1) && (p <= 511);
    endfunction
endpackage

// File: rtl/jtdd_timing_cnt.sv
// 9-bit wrap counter: counts 0..MAX-1 on cen, exposes its next value and a carry
// that is high on the enabled cycle where it wraps.
module jtdd_timing_cnt
    import jtdd_timing_pkg::*;
#(
    parameter int MAX = HTOTAL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    output logic [8:0] cnt,
    output logic [8:0] nxt,
    output logic       carry
);
    localparam logic [8:0] LAST = 9'(MAX - 1);

    always_comb begin
        carry = cen && (cnt == LAST);
        nxt   = cnt;
        if (cen) nxt = carry ? 9'd0 : cnt + 9'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 9'd0;
        else     cnt <= nxt;
    end
endmodule

// File: rtl/jtdd_timing.sv
// Video timing generator: H/V counters plus registered blank, sync and IMS flags,
// decoded from the counters' next values so flags line up with H/V.
module jtdd_timing
    import jtdd_timing_pkg::*;
#(
    parameter int HTOTAL   = HTOTAL_DEF,
    parameter int VTOTAL   = VTOTAL_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int HS_START = HS_START_DEF,
    parameter int HS_LEN   = HS_LEN_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int VB_START = VB_START_DEF,
    parameter int VS_START = VS_START_DEF,
    parameter int VS_LEN   = VS_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    output logic [8:0] H,
    output logic [8:0] V,
    output logic       HBL,
    output logic       VBL,
    output logic       HS,
    output logic       VS,
    output logic       IMS,
    output logic       LHBL,
    output logic       frame_start
);
    logic [8:0] h_nxt, v_nxt;
    logic       h_carry, v_carry;
    logic       hbl_n, vbl_n;

    jtdd_timing_cnt #(.MAX(HTOTAL)) u_hcnt (
        .clk(clk), .rst(rst), .cen(pxl_cen), .cnt(H), .nxt(h_nxt), .carry(h_carry)
    );

    jtdd_timing_cnt #(.MAX(VTOTAL)) u_vcnt (
        .clk(clk), .rst(rst), .cen(h_carry), .cnt(V), .nxt(v_nxt), .carry(v_carry)
    );

    always_comb begin
        hbl_n = int'(h_nxt) >= HB_START;
        vbl_n = (int'(v_nxt) >= VB_START) || (int'(v_nxt) < VB_END);
    end

    // v_nxt only moves on the H wrap, so V flags cannot change mid-line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HBL         <= 1'b0;
            VBL         <= 1'b1;
            HS          <= 1'b0;
            VS          <= 1'b0;
            IMS         <= 1'b0;
            LHBL        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_carry;
            if (pxl_cen) begin
                HBL  <= hbl_n;
                HS   <= in_win(h_nxt, HS_START, HS_LEN);
                VBL  <= vbl_n;
                VS   <= in_win(v_nxt, VS_START, VS_LEN);
                IMS  <= v_nxt[3];
                LHBL <= ~hbl_n & ~vbl_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (param_ok(HTOTAL) && param_ok(VTOTAL) && param_ok(HB_START) &&
                param_ok(HS_START) && param_ok(HS_LEN) && param_ok(VB_END) &&
                param_ok(VB_START) && param_ok(VS_START) && param_ok(VS_LEN))
            else $error("jtdd_timing: timing parameter outside 1..511");
    end
endmodule

// File: tb/tb_jtdd_timing.sv
// Bench for jtdd_timing: a reduced-geometry instance for whole-frame behaviour and
// a default-geometry instance for the real line timing and mid-frame reset.
module tb_jtdd_timing;
    logic clk = 1'b0;
    logic rst, pxl_cen;
    always #5 clk = ~clk;

    logic [8:0] s_h, s_v, d_h, d_v;
    logic s_hbl, s_vbl, s_hs, s_vs, s_ims, s_lhbl, s_fs;
    logic d_hbl, d_vbl, d_hs, d_vs, d_ims, d_lhbl, d_fs;

    // 24 x 48 frame: HB 16.., HS 18..19, VB 40..47 and 0..7, VS 42..44
    jtdd_timing #(
        .HTOTAL(24), .VTOTAL(48), .HB_START(16), .HS_START(18), .HS_LEN(2),
        .VB_END(8), .VB_START(40), .VS_START(42), .VS_LEN(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .H(s_h), .V(s_v), .HBL(s_hbl),
        .VBL(s_vbl), .HS(s_hs), .VS(s_vs), .IMS(s_ims), .LHBL(s_lhbl), .frame_start(s_fs)
    );

    jtdd_timing dut_d (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .H(d_h), .V(d_v), .HBL(d_hbl),
        .VBL(d_vbl), .HS(d_hs), .VS(d_vs), .IMS(d_ims), .LHBL(d_lhbl), .frame_start(d_fs)
    );

    int checks = 0, failures = 0, pcnt = 0, fs_cnt = 0;

    typedef struct {
        int         p;
        logic [8:0] h, v;
        logic       hbl, vbl, hs, vs, ims, lhbl;
    } vec_t;
    vec_t tv[23];

    function automatic vec_t mk(int p, int h, int v, logic hbl, logic vbl, logic hs,
                                logic vs, logic ims, logic lhbl);
        vec_t r;
        r.p = p; r.h = 9'(h); r.v = 9'(v);
        r.hbl = hbl; r.vbl = vbl; r.hs = hs; r.vs = vs; r.ims = ims; r.lhbl = lhbl;
        return r;
    endfunction

    function automatic logic [26:0] pack_s();
        return {s_h, s_v, s_hbl, s_vbl, s_hs, s_vs, s_ims, s_lhbl, s_fs};
    endfunction

    function automatic logic [26:0] pack_d();
        return {d_h, d_v, d_hbl, d_vbl, d_hs, d_vs, d_ims, d_lhbl, d_fs};
    endfunction

    function automatic logic [26:0] exp_pack(int h, int v, logic hbl, logic vbl, logic hs,
                                             logic vs, logic ims, logic lhbl, logic fs);
        return {9'(h), 9'(v), hbl, vbl, hs, vs, ims, lhbl, fs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic cen);
        pxl_cen = cen;
        @(negedge clk);
        if (cen) pcnt++;
        if (s_fs) fs_cnt++;
    endtask

    initial begin
        int bound, n, vbl_rise, ims_rise, first_ims_v, vbl_bad, edge_bad, ims_bad;
        int hs_cnt, vs_cnt, diffs;
        logic pv_vbl, pv_vs, pv_ims;
        logic [26:0] snap;

        tv[0]  = mk(0,    0,  0, 0, 1, 0, 0, 0, 0);
        tv[1]  = mk(1,    1,  0, 0, 1, 0, 0, 0, 0);
        tv[2]  = mk(15,  15,  0, 0, 1, 0, 0, 0, 0);
        tv[3]  = mk(16,  16,  0, 1, 1, 0, 0, 0, 0);
        tv[4]  = mk(18,  18,  0, 1, 1, 1, 0, 0, 0);
        tv[5]  = mk(19,  19,  0, 1, 1, 1, 0, 0, 0);
        tv[6]  = mk(20,  20,  0, 1, 1, 0, 0, 0, 0);
        tv[7]  = mk(23,  23,  0, 1, 1, 0, 0, 0, 0);
        tv[8]  = mk(24,   0,  1, 0, 1, 0, 0, 0, 0);
        tv[9]  = mk(191, 23,  7, 1, 1, 0, 0, 0, 0);
        tv[10] = mk(192,  0,  8, 0, 0, 0, 0, 1, 1);
        tv[11] = mk(200,  8,  8, 0, 0, 0, 0, 1, 1);
        tv[12] = mk(208, 16,  8, 1, 0, 0, 0, 1, 0);
        tv[13] = mk(384,  0, 16, 0, 0, 0, 0, 0, 1);
        tv[14] = mk(576,  0, 24, 0, 0, 0, 0, 1, 1);
        tv[15] = mk(959, 23, 39, 1, 0, 0, 0, 0, 0);
        tv[16] = mk(960,  0, 40, 0, 1, 0, 0, 1, 0);
        tv[17] = mk(1008, 0, 42, 0, 1, 0, 1, 1, 0);
        tv[18] = mk(1079,23, 44, 1, 1, 0, 1, 1, 0);
        tv[19] = mk(1080, 0, 45, 0, 1, 0, 0, 1, 0);
        tv[20] = mk(1151,23, 47, 1, 1, 0, 0, 1, 0);
        tv[21] = mk(1152, 0,  0, 0, 1, 0, 0, 0, 0);
        tv[22] = mk(1344, 0,  8, 0, 0, 0, 0, 1, 1);

        rst = 1'b1; pxl_cen = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_s", 32'(pack_s()), 32'(exp_pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        chk("reset_d", 32'(pack_d()), 32'(exp_pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        pcnt = 0; fs_cnt = 0;

        // gapped pixel enable: one pxl_cen every third clk
        for (int i = 0; i < 23; i++) begin
            while (pcnt < tv[i].p) begin
                tick(1'b1); tick(1'b0); tick(1'b0);
            end
            chk($sformatf("vec_p%0d", tv[i].p), 32'(pack_s()),
                32'(exp_pack(int'(tv[i].h), int'(tv[i].v), tv[i].hbl, tv[i].vbl, tv[i].hs,
                             tv[i].vs, tv[i].ims, tv[i].lhbl, 1'b0)));
        end
        chk("gapped_frame_start_count", 32'(fs_cnt), 32'd1);

        // pxl_cen every clk from here on
        bound = 0;
        while (!s_fs && bound < 3000) begin tick(1'b1); bound++; end
        chk("frame_start_found", 32'(s_fs), 32'd1);

        for (int f = 0; f < 2; f++) begin
            n = 0; vbl_rise = 0; ims_rise = 0; first_ims_v = -1;
            vbl_bad = 0; edge_bad = 0; ims_bad = 0; hs_cnt = 0; vs_cnt = 0;
            pv_vbl = s_vbl; pv_vs = s_vs; pv_ims = s_ims;
            do begin
                tick(1'b1); n++;
                if (s_vbl && !pv_vbl) begin
                    vbl_rise++;
                    if (s_h != 9'd0 || s_v != 9'd40) vbl_bad++;
                end
                if ((s_vbl != pv_vbl || s_vs != pv_vs || s_ims != pv_ims) && s_h != 9'd0)
                    edge_bad++;
                if (s_ims && !pv_ims) begin
                    ims_rise++;
                    if (first_ims_v < 0) first_ims_v = int'(s_v);
                end
                if (s_ims !== s_v[3]) ims_bad++;
                if (s_hs) hs_cnt++;
                if (s_vs) vs_cnt++;
                pv_vbl = s_vbl; pv_vs = s_vs; pv_ims = s_ims;
            end while (!s_fs && n < 5000);
            chk($sformatf("frame%0d_pxl_cen", f), 32'(n), 32'd1152);
            chk($sformatf("frame%0d_fs_pos", f), {14'd0, s_h, s_v}, 32'd0);
            chk($sformatf("frame%0d_vbl_rise", f), 32'(vbl_rise), 32'd1);
            chk($sformatf("frame%0d_vbl_rise_pos", f), 32'(vbl_bad), 32'd0);
            chk($sformatf("frame%0d_vflag_mid_line", f), 32'(edge_bad), 32'd0);
            chk($sformatf("frame%0d_ims_rise", f), 32'(ims_rise), 32'd3);
            chk($sformatf("frame%0d_ims_first_v", f), 32'(first_ims_v), 32'd8);
            chk($sformatf("frame%0d_ims_eq_v3", f), 32'(ims_bad), 32'd0);
            chk($sformatf("frame%0d_hs_width", f), 32'(hs_cnt), 32'd96);
            chk($sformatf("frame%0d_vs_width", f), 32'(vs_cnt), 32'd72);
        end

        for (int i = 0; i < 10; i++) tick(1'b1);
        chk("pre_freeze", 32'(pack_s()), 32'(exp_pack(10, 0, 0, 1, 0, 0, 0, 0, 0)));
        snap = pack_s(); diffs = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0);
            if (pack_s() !== snap) diffs++;
        end
        chk("freeze_no_change", 32'(diffs), 32'd0);
        for (int i = 0; i < 14; i++) tick(1'b1);
        chk("after_freeze_line1", 32'(pack_s()), 32'(exp_pack(0, 1, 0, 1, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 168; i++) tick(1'b1);
        chk("after_freeze_line8", 32'(pack_s()), 32'(exp_pack(0, 8, 0, 0, 0, 0, 1, 1, 0)));

        // default geometry: walk to V=100, H=200, then reset mid-frame
        bound = 0;
        while (!(d_v == 9'd100 && d_h == 9'd200) && bound < 60000) begin
            tick(1'b1); bound++;
        end
        chk("d_reach_v100_h200", {14'd0, d_v, d_h}, {14'd0, 9'd100, 9'd200});
        chk("d_flags_v100_h200", 32'(pack_d()), 32'(exp_pack(200, 100, 0, 0, 0, 0, 0, 1, 0)));

        #2 rst = 1'b1;
        #1;
        chk("async_reset_d", 32'(pack_d()), 32'(exp_pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        chk("async_reset_s", 32'(pack_s()), 32'(exp_pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        pxl_cen = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        tick(1'b1);
        chk("d_first_cen", 32'(pack_d()), 32'(exp_pack(1, 0, 0, 1, 0, 0, 0, 0, 0)));
        chk("s_first_cen", 32'(pack_s()), 32'(exp_pack(1, 0, 0, 1, 0, 0, 0, 0, 0)));
        hs_cnt = 0;
        for (int i = 2; i <= 384; i++) begin
            tick(1'b1);
            if (d_hs) hs_cnt++;
            if (i == 255) chk("d_hbl_h255", {22'd0, d_h, d_hbl}, {22'd0, 9'd255, 1'b0});
            if (i == 256) chk("d_hbl_h256", {22'd0, d_h, d_hbl}, {22'd0, 9'd256, 1'b1});
            if (i == 287) chk("d_hs_h287", {22'd0, d_h, d_hs}, {22'd0, 9'd287, 1'b0});
            if (i == 288) chk("d_hs_h288", {22'd0, d_h, d_hs}, {22'd0, 9'd288, 1'b1});
            if (i == 320) chk("d_hs_h320", {22'd0, d_h, d_hs}, {22'd0, 9'd320, 1'b0});
        end
        chk("d_hs_width", 32'(hs_cnt), 32'd32);
        chk("d_line1_after_384", 32'(pack_d()), 32'(exp_pack(0, 1, 0, 1, 0, 0, 0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
